conv33_window_gen: RTL and testbench
====================================

CONV33_WINDOW_GEN -- requirements
Module: conv33_window_gen

Interface
REQ-001 SHALL have parameter IMG_W, default 16, meaning pixels per row (3..64).
REQ-002 SHALL have parameter IMG_H, default 16, meaning rows per frame (3..64).
REQ-003 SHALL have parameter NUM_ADDR, default 4, meaning PIM addresses issued per window (1..32).
REQ-004 SHALL have port clk, input, 1 bit: the single clock.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port pix_in, input, 6 bits: raster-order pixel.
REQ-007 SHALL have port pix_valid, input, 1 bit: pix_in is valid.
REQ-008 SHALL have port pix_sof, input, 1 bit: qualifies pix_in as pixel (0,0) of a new frame.
REQ-009 SHALL have port pix_ready, output, 1 bit: a pixel is accepted when pix_valid and pix_ready are both high.
REQ-010 SHALL have ports in_data_0..in_data_8, output, 6 bits each: 3x3 window taps, row-major, in_data_0 top-left (oldest), in_data_8 bottom-right (newest).
REQ-011 SHALL have port Add_pim, output, 5 bits: PIM address.
REQ-012 SHALL have port Compute_flag, output, 1 bit: taps and Add_pim are valid for the conv stage.
REQ-013 SHALL have port win_last, output, 1 bit: marks the last address of a window.
REQ-014 SHALL have port frame_done, output, 1 bit: one-cycle pulse at the end of a frame.

Function
REQ-015 SHALL hold an FSM with states ACCEPT and ISSUE; pix_ready SHALL be 1 only in ACCEPT while rst_n is high.
REQ-016 SHALL track a column counter (0..IMG_W-1) and a row counter (0..IMG_H-1); each accept advances the column; at IMG_W-1 the column wraps to 0 and the row increments.
REQ-017 SHALL store the two previous rows in line buffers, so the taps are rows r-2, r-1, r at columns c-2, c-1, c.
REQ-018 SHALL, on accepting pixel (r,c) with r>=2 and c>=2, latch the nine taps and enter ISSUE in the next cycle; otherwise it SHALL remain in ACCEPT.
REQ-019 SHALL, in ISSUE, drive Compute_flag=1 and Add_pim=0,1,..,NUM_ADDR-1 on consecutive cycles, holding the taps stable throughout.
REQ-020 SHALL assert win_last together with Add_pim=NUM_ADDR-1 and return to ACCEPT in the following cycle.
REQ-021 SHALL produce the first Compute_flag exactly 1 cycle after the triggering accept; window throughput is one window per NUM_ADDR+1 cycles.
REQ-022 SHALL drive Compute_flag=0 in ACCEPT; there Add_pim SHALL be 0 and the taps SHALL hold their last values.
REQ-023 SHALL, on the win_last cycle of window (IMG_H-1,IMG_W-1), pulse frame_done and clear both counters to 0.
REQ-024 SHALL treat an accepted pixel with pix_sof=1 as (0,0) regardless of counter state; a partially received frame is discarded without a frame_done pulse.
REQ-025 SHALL ignore pix_sof and pix_in whenever pix_ready=0.
REQ-026 SHALL never produce windows that span a row wrap, i.e. windows with c<2.

Reset
REQ-027 SHALL, while rst_n=0, force the state to ACCEPT, the counters to 0, the taps to 0, Add_pim=0, and Compute_flag, win_last, frame_done and pix_ready to 0.
REQ-028 SHALL, on reset asserted mid-ISSUE, abort the window immediately with no win_last; after release it SHALL wait for a new frame at (0,0).
REQ-029 SHALL NOT require the line buffer contents to be reset.

Structure
REQ-030 SHALL take PIX_W=6, ADDR_W=5 and the FSM state enumeration from the shared package conv33_pkg.
REQ-031 SHALL instantiate one sub-module, conv33_line_buffer: an IMG_W-deep, PIX_W-wide row delay with a write-enable equal to the accept.

Verification (IMG_W=4, IMG_H=4, NUM_ADDR=3)
REQ-032 SHALL cover: pixels 0..15 with pix_valid held at 1 and pix_sof on pixel 0 -> first Compute_flag 1 cycle after pixel 10 is accepted, taps {0,1,2,4,5,6,8,9,10}, Add_pim 0,1,2, win_last with Add_pim=2; exactly 4 windows; frame_done on the win_last of the window ending in 15.
REQ-033 SHALL cover backpressure -> pix_ready=0 for exactly 3 cycles after each window-triggering accept, with no pixel lost or duplicated.
REQ-034 SHALL cover random pix_valid gaps -> identical tap and address sequence to the no-gap case.
REQ-035 SHALL cover pix_sof asserted on the 7th pixel -> counting restarts, no frame_done for the aborted frame, and the first window appears after 11 pixels of the new frame.
REQ-036 SHALL cover rst_n low while Add_pim=1 -> all outputs 0 asynchronously, no win_last, and correct windows for the next full frame.

Source files
------------

// File: rtl/conv33_pkg.sv
// Shared widths, FSM state encoding and the column payload for the 3x3 window generator.
package conv33_pkg;

  localparam int unsigned PIX_W  = 6;
  localparam int unsigned ADDR_W = 5;

  typedef enum logic {
    ACCEPT = 1'b0,
    ISSUE  = 1'b1
  } state_t;

  // One vertical slice of the window: rows r-2, r-1, r at a single column.
  typedef struct packed {
    logic [PIX_W-1:0] top;
    logic [PIX_W-1:0] mid;
    logic [PIX_W-1:0] bot;
  } column_t;

endpackage

// File: rtl/conv33_line_buffer.sv
// One-row pixel delay: dout is the pixel written DEPTH accepts earlier.
module conv33_line_buffer
  import conv33_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [PIX_W-1:0] din,
  output logic [PIX_W-1:0] dout
);

  logic [PIX_W-1:0] mem [DEPTH];

  // Contents need no reset: a window is only formed after two full rows are written.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[0] <= din;
      for (int i = 1; i < int'(DEPTH); i++) begin
        mem[i] <= mem[i-1];
      end
    end
  end

  assign dout = mem[DEPTH-1];

endmodule

// File: rtl/conv33_window_gen.sv
// Raster pixel stream to 3x3 windows; each window is held while NUM_ADDR PIM addresses issue.
module conv33_window_gen
  import conv33_pkg::*;
#(
  parameter int unsigned IMG_W    = 16,
  parameter int unsigned IMG_H    = 16,
  parameter int unsigned NUM_ADDR = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PIX_W-1:0]  pix_in,
  input  logic              pix_valid,
  input  logic              pix_sof,
  output logic              pix_ready,
  output logic [PIX_W-1:0]  in_data_0,
  output logic [PIX_W-1:0]  in_data_1,
  output logic [PIX_W-1:0]  in_data_2,
  output logic [PIX_W-1:0]  in_data_3,
  output logic [PIX_W-1:0]  in_data_4,
  output logic [PIX_W-1:0]  in_data_5,
  output logic [PIX_W-1:0]  in_data_6,
  output logic [PIX_W-1:0]  in_data_7,
  output logic [PIX_W-1:0]  in_data_8,
  output logic [ADDR_W-1:0] Add_pim,
  output logic              Compute_flag,
  output logic              win_last,
  output logic              frame_done
);

  localparam int unsigned COL_W = $clog2(IMG_W);
  localparam int unsigned ROW_W = $clog2(IMG_H);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_ADDR - 1);
  localparam logic SINGLE_ADDR = (NUM_ADDR == 1);

  state_t            state_q;
  logic [COL_W-1:0]  col_q;
  logic [ROW_W-1:0]  row_q;
  logic              last_win_q;
  column_t           hist1_q;
  column_t           hist2_q;
  logic [PIX_W-1:0]  taps_q [9];

  logic              accept;
  logic              trigger;
  logic              col_end;
  logic              row_end;
  logic              is_last_pos;
  logic [COL_W-1:0]  col_eff;
  logic [ROW_W-1:0]  row_eff;
  logic [PIX_W-1:0]  lb1_out;
  logic [PIX_W-1:0]  lb2_out;
  logic [ADDR_W-1:0] add_nxt;
  column_t           new_col;

  conv33_line_buffer #(.DEPTH(IMG_W)) u_lb1 (
    .clk   (clk),
    .wr_en (accept),
    .din   (pix_in),
    .dout  (lb1_out)
  );

  conv33_line_buffer #(.DEPTH(IMG_W)) u_lb2 (
    .clk   (clk),
    .wr_en (accept),
    .din   (lb1_out),
    .dout  (lb2_out)
  );

  // A start-of-frame pixel is placed at (0,0) whatever the counters say.
  assign accept      = pix_valid & pix_ready;
  assign col_eff     = pix_sof ? '0 : col_q;
  assign row_eff     = pix_sof ? '0 : row_q;
  assign col_end     = (col_eff == COL_W'(IMG_W - 1));
  assign row_end     = (row_eff == ROW_W'(IMG_H - 1));
  assign is_last_pos = col_end & row_end;
  assign trigger     = accept & (row_eff >= ROW_W'(2)) & (col_eff >= COL_W'(2));
  assign new_col     = '{top: lb2_out, mid: lb1_out, bot: pix_in};
  assign add_nxt     = Add_pim + ADDR_W'(1);

  // Position counters and the two previous columns of the window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q   <= '0;
      row_q   <= '0;
      hist1_q <= '0;
      hist2_q <= '0;
    end else if (accept) begin
      col_q   <= col_end ? '0 : COL_W'(col_eff + COL_W'(1));
      row_q   <= !col_end ? row_eff : (row_end ? '0 : ROW_W'(row_eff + ROW_W'(1)));
      hist1_q <= new_col;
      hist2_q <= hist1_q;
    end else if (frame_done) begin
      col_q <= '0;
      row_q <= '0;
    end
  end

  // Accept/issue control with registered handshake, address and window outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ACCEPT;
      pix_ready    <= 1'b0;
      Compute_flag <= 1'b0;
      Add_pim      <= '0;
      win_last     <= 1'b0;
      frame_done   <= 1'b0;
      last_win_q   <= 1'b0;
      for (int i = 0; i < 9; i++) taps_q[i] <= '0;
    end else begin
      case (state_q)
        ACCEPT: begin
          pix_ready    <= 1'b1;
          Compute_flag <= 1'b0;
          Add_pim      <= '0;
          win_last     <= 1'b0;
          frame_done   <= 1'b0;
          if (trigger) begin
            state_q      <= ISSUE;
            pix_ready    <= 1'b0;
            Compute_flag <= 1'b1;
            win_last     <= SINGLE_ADDR;
            frame_done   <= SINGLE_ADDR & is_last_pos;
            last_win_q   <= is_last_pos;
            taps_q[0]    <= hist2_q.top;
            taps_q[1]    <= hist1_q.top;
            taps_q[2]    <= lb2_out;
            taps_q[3]    <= hist2_q.mid;
            taps_q[4]    <= hist1_q.mid;
            taps_q[5]    <= lb1_out;
            taps_q[6]    <= hist2_q.bot;
            taps_q[7]    <= hist1_q.bot;
            taps_q[8]    <= pix_in;
          end
        end
        ISSUE: begin
          if (win_last) begin
            state_q      <= ACCEPT;
            pix_ready    <= 1'b1;
            Compute_flag <= 1'b0;
            Add_pim      <= '0;
            win_last     <= 1'b0;
            frame_done   <= 1'b0;
          end else begin
            Add_pim    <= add_nxt;
            win_last   <= (add_nxt == LAST_ADDR);
            frame_done <= (add_nxt == LAST_ADDR) & last_win_q;
          end
        end
        default: state_q <= ACCEPT;
      endcase
    end
  end

  assign in_data_0 = taps_q[0];
  assign in_data_1 = taps_q[1];
  assign in_data_2 = taps_q[2];
  assign in_data_3 = taps_q[3];
  assign in_data_4 = taps_q[4];
  assign in_data_5 = taps_q[5];
  assign in_data_6 = taps_q[6];
  assign in_data_7 = taps_q[7];
  assign in_data_8 = taps_q[8];

endmodule

// File: tb/tb_conv33_window_gen.sv
// Directed bench for conv33_window_gen on a 4x4 image with 3 addresses per window.
module tb_conv33_window_gen;

  localparam int unsigned IMG_W    = 4;
  localparam int unsigned IMG_H    = 4;
  localparam int unsigned NUM_ADDR = 3;
  localparam int NWIN = 4;
  localparam int NREC = NWIN * int'(NUM_ADDR);

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] pix_in;
  logic       pix_valid;
  logic       pix_sof;
  logic       pix_ready;
  logic [5:0] in_data_0, in_data_1, in_data_2, in_data_3, in_data_4;
  logic [5:0] in_data_5, in_data_6, in_data_7, in_data_8;
  logic [4:0] Add_pim;
  logic       Compute_flag;
  logic       win_last;
  logic       frame_done;

  conv33_window_gen #(
    .IMG_W    (IMG_W),
    .IMG_H    (IMG_H),
    .NUM_ADDR (NUM_ADDR)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pix_in       (pix_in),
    .pix_valid    (pix_valid),
    .pix_sof      (pix_sof),
    .pix_ready    (pix_ready),
    .in_data_0    (in_data_0),
    .in_data_1    (in_data_1),
    .in_data_2    (in_data_2),
    .in_data_3    (in_data_3),
    .in_data_4    (in_data_4),
    .in_data_5    (in_data_5),
    .in_data_6    (in_data_6),
    .in_data_7    (in_data_7),
    .in_data_8    (in_data_8),
    .Add_pim      (Add_pim),
    .Compute_flag (Compute_flag),
    .win_last     (win_last),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0][5:0] taps;
    logic [4:0]      addr;
    logic            last;
    logic            fd;
  } exp_t;

  typedef struct {
    logic [8:0][5:0] taps;
    logic [4:0]      addr;
    logic            last;
    logic            fd;
    int              cyc;
  } obs_t;

  exp_t exp_tbl [NREC];
  obs_t log_q [$];
  obs_t mon_o;
  int   runs [$];
  int   acc_cyc [16];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   fd_cnt = 0;
  int   run = 0;
  bit   rr_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe the issue stream, frame_done pulses and pix_ready low runs.
  always @(negedge clk) begin
    if (rst_n && Compute_flag) begin
      mon_o.taps = {in_data_8, in_data_7, in_data_6, in_data_5, in_data_4,
                    in_data_3, in_data_2, in_data_1, in_data_0};
      mon_o.addr = Add_pim;
      mon_o.last = win_last;
      mon_o.fd   = frame_done;
      mon_o.cyc  = cyc;
      log_q.push_back(mon_o);
    end
    if (frame_done) fd_cnt++;
    if (rr_en) begin
      if (!pix_ready) run++;
      else if (run > 0) begin
        runs.push_back(run);
        run = 0;
      end
    end
  end

  task automatic chk(input string nm, input bit ok, input string got, input string want);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %s, expected %s", nm, got, want);
    end
  endtask

  task automatic send_pix(input logic [5:0] v, input logic sof, output int acc);
    bit rdy;
    int waited = 0;
    pix_in = v;
    pix_sof = sof;
    pix_valid = 1'b1;
    acc = -1;
    do begin
      rdy = pix_ready;
      @(negedge clk);
      waited++;
    end while (!rdy && waited < 40);
    if (rdy) acc = cyc;
    else begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: pixel %0d not accepted within 40 cycles", v);
    end
  endtask

  task automatic idle(input int n);
    pix_valid = 1'b0;
    pix_sof = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input int max_gap);
    int a;
    for (int i = 0; i < 16; i++) begin
      if (max_gap > 0) idle(int'($urandom_range(0, max_gap)));
      send_pix(6'(i), i == 0, a);
      acc_cyc[i] = a;
    end
    idle(8);
  endtask

  task automatic check_frame(input string tag);
    int n = log_q.size();
    obs_t o;
    bit ok;
    chk({tag, "_count"}, n == NREC, $sformatf("%0d records", n), $sformatf("%0d records", NREC));
    for (int i = 0; i < NREC; i++) begin
      o = (i < n) ? log_q[i] : '{default: '0};
      ok = (i < n) && o.taps == exp_tbl[i].taps && o.addr == exp_tbl[i].addr &&
           o.last == exp_tbl[i].last && o.fd == exp_tbl[i].fd;
      chk($sformatf("%s_rec%0d", tag, i), ok,
          $sformatf("taps=%h addr=%0d last=%0b fd=%0b", o.taps, o.addr, o.last, o.fd),
          $sformatf("taps=%h addr=%0d last=%0b fd=%0b", exp_tbl[i].taps, exp_tbl[i].addr,
                    exp_tbl[i].last, exp_tbl[i].fd));
    end
  endtask

  function automatic bit outs_zero();
    return !pix_ready && !Compute_flag && !win_last && !frame_done && Add_pim == 5'd0;
  endfunction

  function automatic logic [8:0][5:0] taps_now();
    return {in_data_8, in_data_7, in_data_6, in_data_5, in_data_4,
            in_data_3, in_data_2, in_data_1, in_data_0};
  endfunction

  initial begin
    int wt [NWIN][9];
    int a;
    int nlast;
    bit all3;
    wt = '{'{0, 1, 2, 4, 5, 6, 8, 9, 10},
           '{1, 2, 3, 5, 6, 7, 9, 10, 11},
           '{4, 5, 6, 8, 9, 10, 12, 13, 14},
           '{5, 6, 7, 9, 10, 11, 13, 14, 15}};
    for (int w = 0; w < NWIN; w++) begin
      for (int k = 0; k < int'(NUM_ADDR); k++) begin
        for (int t = 0; t < 9; t++) exp_tbl[w*3+k].taps[t] = 6'(wt[w][t]);
        exp_tbl[w*3+k].addr = 5'(k);
        exp_tbl[w*3+k].last = (k == 2);
        exp_tbl[w*3+k].fd   = (w == NWIN - 1) && (k == 2);
      end
    end

    // Reset holds everything low even with a valid pixel presented.
    rst_n = 1'b0;
    pix_valid = 1'b1;
    pix_in = 6'h3f;
    pix_sof = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", outs_zero(),
        $sformatf("rdy=%0b flag=%0b last=%0b fd=%0b addr=%0d", pix_ready, Compute_flag, win_last, frame_done, Add_pim),
        "all zero");
    chk("reset_taps", taps_now() == '0, $sformatf("%h", taps_now()), "0");
    idle(0);
    rst_n = 1'b1;
    @(negedge clk);

    // Continuous stream, one frame.
    log_q.delete();
    fd_cnt = 0;
    rr_en = 1'b1;
    send_frame(0);
    rr_en = 1'b0;
    check_frame("nogap");
    chk("nogap_first_flag", log_q.size() > 0 && log_q[0].cyc == acc_cyc[10],
        $sformatf("cycle %0d", (log_q.size() > 0) ? log_q[0].cyc : -1),
        $sformatf("cycle %0d", acc_cyc[10]));
    chk("nogap_frame_done", fd_cnt == 1, $sformatf("%0d", fd_cnt), "1");
    all3 = 1'b1;
    foreach (runs[i]) if (runs[i] != 3) all3 = 1'b0;
    chk("ready_low_runs", runs.size() == NWIN && all3,
        $sformatf("%0d runs, all3=%0b", runs.size(), all3), $sformatf("%0d runs of 3", NWIN));

    // Random pix_valid gaps give the same issue sequence.
    log_q.delete();
    fd_cnt = 0;
    send_frame(2);
    check_frame("gaps");
    chk("gaps_frame_done", fd_cnt == 1, $sformatf("%0d", fd_cnt), "1");

    // Partial frame of six pixels aborted by a new start-of-frame.
    log_q.delete();
    fd_cnt = 0;
    for (int i = 0; i < 6; i++) send_pix(6'(40 + i), i == 0, a);
    send_frame(0);
    check_frame("sof");
    chk("sof_frame_done", fd_cnt == 1, $sformatf("%0d", fd_cnt), "1");
    chk("sof_first_flag", log_q.size() > 0 && log_q[0].cyc == acc_cyc[10],
        $sformatf("cycle %0d", (log_q.size() > 0) ? log_q[0].cyc : -1),
        $sformatf("cycle %0d", acc_cyc[10]));

    // Reset asserted while the first window is at address 1.
    log_q.delete();
    fd_cnt = 0;
    for (int i = 0; i < 11; i++) send_pix(6'(i), i == 0, a);
    idle(0);
    for (int k = 0; k < 10 && !(Compute_flag && Add_pim == 5'd1); k++) @(negedge clk);
    chk("midreset_reach_addr1", Compute_flag && Add_pim == 5'd1,
        $sformatf("flag=%0b addr=%0d", Compute_flag, Add_pim), "flag=1 addr=1");
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_ctrl_async", outs_zero(),
        $sformatf("rdy=%0b flag=%0b last=%0b fd=%0b addr=%0d", pix_ready, Compute_flag, win_last, frame_done, Add_pim),
        "all zero");
    chk("midreset_taps_async", taps_now() == '0, $sformatf("%h", taps_now()), "0");
    nlast = 0;
    foreach (log_q[i]) if (log_q[i].last) nlast++;
    chk("midreset_no_win_last", nlast == 0 && fd_cnt == 0,
        $sformatf("win_last=%0d fd=%0d", nlast, fd_cnt), "win_last=0 fd=0");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    log_q.delete();
    fd_cnt = 0;
    send_frame(0);
    check_frame("postreset");
    chk("postreset_frame_done", fd_cnt == 1, $sformatf("%0d", fd_cnt), "1");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
